board_pixel_renderer: RTL

Parametrised successor to the single-piece colour mapper. Renders the full Tetris board from a row-fetched cell memory, overlays an N-block active piece, and maps 4-bit cell colour indices through a palette. Sits between the VGA timing generator (DrawX/DrawY) and the VGA DAC outputs. Includes a line-rate row-prefetch FSM with a req/ack handshake to the board RAM, and a 2-stage pixel pipeline.

---
 rtl/board_render_pkg.sv | 20 ++
 rtl/row_fetch_ctrl.sv | 130 +++++++++++++
 rtl/board_pixel_renderer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/board_render_pkg.sv
// Shared constants for the board pixel renderer: palette, fixed colours, fetch states.
package board_render_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    localparam logic [23:0] BORDER_RGB = 24'hFF5500;
    localparam logic [23:0] GRID_RGB   = 24'h404040;

    // Entry 0 is never shown: an index of 0 means an empty cell.
    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'h00FFFF, 24'h0000FF, 24'hFF8000,
        24'hFFFF00, 24'h00FF00, 24'h800080, 24'hFF0000,
        24'h808080, 24'hFFFFFF, 24'h404080, 24'h80C0FF,
        24'hFFC0C0, 24'hC0FFC0, 24'h602000, 24'hFF00FF
    };

endpackage

// File: rtl/row_fetch_ctrl.sv
// Vertical cell tracking, line-rate row prefetch over a req/ack handshake, row buffer.
// GRID_LINES_EN adds the sub_y_out port used for horizontal grid lines.
module row_fetch_ctrl
    import board_render_pkg::*;
#(
    parameter int BOARD_W  = 10,
    parameter int BOARD_H  = 20,
    parameter int CELL_PX  = 21,
    parameter int ORIGIN_Y = 0,
    parameter int V_LAST   = 524
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           draw_y,
    input  logic                 line_end,
    input  logic                 row_ack,
    input  logic [4*BOARD_W-1:0] row_data,
    output logic                 row_req,
    output logic [4:0]           row_addr,
    output logic                 underrun,
    output logic [4*BOARD_W-1:0] row_buf,
    output logic [4:0]           cell_row,
    output logic                 line_in_board
`ifdef GRID_LINES_EN
    ,
    output logic [4:0]           sub_y_out
`endif
);

    localparam int Y_END = ORIGIN_Y + BOARD_H * CELL_PX;

    fetch_state_t state_r;
    logic [4:0]   sub_y_r;
    logic [9:0]   next_y_s;
    logic         next_in_s;
    logic [4:0]   cell_row_n_s;
    logic [4:0]   sub_y_n_s;
    logic         in_board_n_s;
    logic         fetch_due_s;
    logic [4:0]   fetch_row_s;

`ifdef GRID_LINES_EN
    assign sub_y_out = sub_y_r;
`endif

    // Next-line counter update and fetch decision, evaluated on line_end only.
    always_comb begin
        next_y_s     = (draw_y == 10'(V_LAST)) ? 10'd0 : draw_y + 10'd1;
        next_in_s    = ({1'b0, next_y_s} >= 11'(ORIGIN_Y)) && ({1'b0, next_y_s} < 11'(Y_END));
        cell_row_n_s = cell_row;
        sub_y_n_s    = sub_y_r;
        in_board_n_s = line_in_board;
        fetch_due_s  = 1'b0;
        fetch_row_s  = 5'd0;
        if (line_end) begin
            in_board_n_s = next_in_s;
            if (next_y_s == 10'(ORIGIN_Y)) begin
                cell_row_n_s = 5'd0;
                sub_y_n_s    = 5'd0;
                fetch_due_s  = 1'b1;
                fetch_row_s  = 5'd0;
            end else if (next_in_s) begin
                if (sub_y_r == 5'(CELL_PX - 1)) begin
                    sub_y_n_s    = 5'd0;
                    cell_row_n_s = cell_row + 5'd1;
                    fetch_due_s  = ({1'b0, cell_row} + 6'd1) < 6'(BOARD_H);
                    fetch_row_s  = cell_row + 5'd1;
                end else begin
                    sub_y_n_s = sub_y_r + 5'd1;
                end
            end else begin
                cell_row_n_s = cell_row;
                sub_y_n_s    = sub_y_r;
            end
        end else begin
            in_board_n_s = line_in_board;
        end
    end

    // Vertical counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_row      <= 5'd0;
            sub_y_r       <= 5'd0;
            line_in_board <= 1'b0;
        end else begin
            cell_row      <= cell_row_n_s;
            sub_y_r       <= sub_y_n_s;
            line_in_board <= in_board_n_s;
        end
    end

    // Fetch FSM; a line_end while still waiting is an underrun and retargets the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            row_req  <= 1'b0;
            row_addr <= 5'd0;
            underrun <= 1'b0;
            row_buf  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fetch_due_s) begin
                        row_req  <= 1'b1;
                        row_addr <= fetch_row_s;
                        state_r  <= REQ;
                    end
                end
                REQ: begin
                    if (row_ack) begin
                        row_buf <= row_data;
                        row_req <= 1'b0;
                        state_r <= IDLE;
                    end else if (line_end) begin
                        underrun <= 1'b1;
                        if (fetch_due_s) begin
                            row_addr <= fetch_row_s;
                        end
                    end
                end
                default: begin
                    row_req <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/board_pixel_renderer.sv
// Full-board Tetris renderer: row prefetch plus 2-stage pixel pipeline with piece overlay.
// Optional grid lines are enabled by defining GRID_LINES_EN.
module board_pixel_renderer
    import board_render_pkg::*;
#(
    parameter int BOARD_W      = 10,
    parameter int BOARD_H      = 20,
    parameter int CELL_PX      = 21,
    parameter int ORIGIN_X     = 213,
    parameter int ORIGIN_Y     = 0,
    parameter int PIECE_BLOCKS = 4,
    parameter int V_LAST       = 524
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      line_end,
    output logic                      row_req,
    output logic [4:0]                row_addr,
    input  logic                      row_ack,
    input  logic [4*BOARD_W-1:0]      row_data,
    input  logic [5*PIECE_BLOCKS-1:0] piece_x,
    input  logic [5*PIECE_BLOCKS-1:0] piece_y,
    input  logic [3:0]                piece_color,
    input  logic                      piece_valid,
    output logic [7:0]                Red,
    output logic [7:0]                Green,
    output logic [7:0]                Blue,
    output logic                      underrun
);

    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + BOARD_W * CELL_PX);

    logic [4*BOARD_W-1:0] row_buf_s;
    logic [4:0]           cell_row_s;
    logic                 line_in_board_s;
    logic [9:0]           dx_s;
    logic [4:0]           col_s;
    logic                 in_board_s;
    logic                 hit_s;
    logic                 in_board_r;
    logic [4:0]           col_r;
    logic                 piece_hit_r;
    logic [6:0]           xhi_r;
    logic [3:0]           cell_idx_s;
    logic [23:0]          rgb_s;
`ifdef GRID_LINES_EN
    logic [4:0]           sub_y_s;
    logic [4:0]           sub_x_s;
    logic [4:0]           sub_x_r;
    logic                 grid_y_r;
`endif

    row_fetch_ctrl #(
        .BOARD_W  (BOARD_W),
        .BOARD_H  (BOARD_H),
        .CELL_PX  (CELL_PX),
        .ORIGIN_Y (ORIGIN_Y),
        .V_LAST   (V_LAST)
    ) u_fetch (
        .clk           (Clk),
        .reset         (reset),
        .draw_y        (DrawY),
        .line_end      (line_end),
        .row_ack       (row_ack),
        .row_data      (row_data),
        .row_req       (row_req),
        .row_addr      (row_addr),
        .underrun      (underrun),
        .row_buf       (row_buf_s),
        .cell_row      (cell_row_s),
        .line_in_board (line_in_board_s)
`ifdef GRID_LINES_EN
        ,
        .sub_y_out     (sub_y_s)
`endif
    );

    // Stage 1 decode: horizontal cell position and piece overlap for the current row.
    always_comb begin
        dx_s       = DrawX - 10'(ORIGIN_X);
        col_s      = 5'(dx_s / 10'(CELL_PX));
        in_board_s = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) && line_in_board_s;
        hit_s      = 1'b0;
        for (int k = 0; k < PIECE_BLOCKS; k++) begin
            hit_s = hit_s | ((piece_x[5*k +: 5] == col_s) && (piece_y[5*k +: 5] == cell_row_s) &&
                             (piece_x[5*k +: 5] < 5'(BOARD_W)) && (piece_y[5*k +: 5] < 5'(BOARD_H)));
        end
        hit_s = hit_s & piece_valid;
`ifdef GRID_LINES_EN
        sub_x_s = 5'(dx_s % 10'(CELL_PX));
`endif
    end

    // Stage 1 registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            in_board_r  <= 1'b0;
            col_r       <= 5'd0;
            piece_hit_r <= 1'b0;
            xhi_r       <= 7'd0;
`ifdef GRID_LINES_EN
            sub_x_r     <= 5'd0;
            grid_y_r    <= 1'b0;
`endif
        end else begin
            in_board_r  <= in_board_s;
            col_r       <= col_s;
            piece_hit_r <= hit_s;
            xhi_r       <= DrawX[9:3];
`ifdef GRID_LINES_EN
            sub_x_r     <= sub_x_s;
            grid_y_r    <= (sub_y_s == 5'd0);
`endif
        end
    end

    // Stage 2 colour priority: border, piece, grid, cell, background.
    always_comb begin
        cell_idx_s = 4'd0;
        for (int c = 0; c < BOARD_W; c++) begin
            cell_idx_s = (col_r == 5'(c)) ? row_buf_s[4*c +: 4] : cell_idx_s;
        end
        if (!in_board_r) begin
            rgb_s = BORDER_RGB;
        end else if (piece_hit_r) begin
            rgb_s = PALETTE[piece_color];
`ifdef GRID_LINES_EN
        end else if ((sub_x_r == 5'd0) || grid_y_r) begin
            rgb_s = GRID_RGB;
`endif
        end else if (cell_idx_s != 4'd0) begin
            rgb_s = PALETTE[cell_idx_s];
        end else begin
            rgb_s = {16'h0000, 8'h7F - {1'b0, xhi_r}};
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            Red   <= 8'd0;
            Green <= 8'd0;
            Blue  <= 8'd0;
        end else begin
            Red   <= rgb_s[23:16];
            Green <= rgb_s[15:8];
            Blue  <= rgb_s[7:0];
        end
    end

endmodule
